// File: rtl/distribute_1x2_branch_buffer_pkg.sv
// Shared branch indices and switch command encodings for the 1x2 distribute path.
package distribute_1x2_branch_buffer_pkg;

  localparam int BR_LOW  = 0;
  localparam int BR_HIGH = 1;

  typedef enum logic [1:0] {
    CMD_NA   = 2'b00,
    CMD_LOW  = 2'b01,
    CMD_HIGH = 2'b10,
    CMD_DUP  = 2'b11
  } cmd_e;

endpackage

// File: rtl/distribute_1x2_branch_buffer_fifo.sv
// First-word fall-through synchronous FIFO; the head word is always presented on dout.
module sync_fifo_fwft
  import distribute_1x2_branch_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == (PTR_WIDTH+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale contents are masked by empty at the top level.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/distribute_1x2_branch_buffer.sv
// Buffers the two branch outputs of the 1x2 distribute switch into per-branch FWFT FIFOs.
module distribute_1x2_branch_buffer
  import distribute_1x2_branch_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  output logic                    o_ready,
  output logic [1:0]              o_valid,
  output logic [2*DATA_WIDTH-1:0] o_data_bus,
  input  logic [1:0]              i_ready,
  output logic [1:0]              o_full,
  output logic [1:0]              o_empty
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  cmd_e                  cmd;
  logic                  transfer;
  logic [1:0]            push, pop;
  logic [DATA_WIDTH-1:0] head [2];

  // Ready looks only at the full flags so the switch sees no loop through i_valid,
  // and a duplicate is only accepted when both branches have room.
  assign o_ready  = ~rst & ~o_full[BR_HIGH] & ~o_full[BR_LOW];
  assign cmd      = cmd_e'(i_valid);
  assign transfer = (cmd != CMD_NA) & o_ready;

  for (genvar b = 0; b < 2; b++) begin : g_branch
    assign push[b]    = transfer & i_valid[b];
    assign pop[b]     = o_valid[b] & i_ready[b];
    assign o_valid[b] = ~o_empty[b];
    assign o_data_bus[b*DATA_WIDTH +: DATA_WIDTH] = o_empty[b] ? '0 : head[b];

    sync_fifo_fwft #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[b]),
      .din   (i_data_bus[b*DATA_WIDTH +: DATA_WIDTH]),
      .pop   (pop[b]),
      .dout  (head[b]),
      .full  (o_full[b]),
      .empty (o_empty[b])
    );
  end

  if (FIFO_DEPTH < 2 || (1 << PTR_WIDTH) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

endmodule

// File: tb/tb_distribute_1x2_branch_buffer.sv
// Directed bench for the 1x2 branch buffer with hand-computed expectations.
module tb_distribute_1x2_branch_buffer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic          o_ready;
  logic [1:0]    o_valid;
  logic [2*DW-1:0] o_data_bus;
  logic [1:0]    i_ready;
  logic [1:0]    o_full;
  logic [1:0]    o_empty;

  int checks = 0;
  int errors = 0;

  distribute_1x2_branch_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus),
    .i_ready    (i_ready),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 2'b00; i_data_bus = '0; i_ready = 2'b00;
    step();
    check_eq("ready_in_rst", 64'(o_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_empty", 64'(o_empty), 64'd3);
    check_eq("rst_full",  64'(o_full),  64'd0);
    check_eq("rst_ready", 64'(o_ready), 64'd1);
    check_eq("rst_bus",   o_data_bus,   64'd0);

    // Single-branch low word
    i_valid = 2'b01; i_data_bus = {32'h0, 32'hA5A5_0001};
    step();
    i_valid = 2'b00; i_data_bus = '0;
    check_eq("low_valid", 64'(o_valid), 64'd1);
    check_eq("low_bus",   o_data_bus,   {32'h0, 32'hA5A5_0001});
    i_ready = 2'b01;
    step();
    check_eq("low_pop_valid", 64'(o_valid), 64'd0);
    check_eq("low_pop_bus",   o_data_bus,   64'd0);

    // Duplicate, low drains first, high waits
    i_valid = 2'b11; i_data_bus = {32'h1234_5678, 32'h1234_5678};
    step();
    i_valid = 2'b00; i_data_bus = '0;
    check_eq("dup_valid", 64'(o_valid), 64'd3);
    check_eq("dup_bus",   o_data_bus,   {32'h1234_5678, 32'h1234_5678});
    step();
    check_eq("dup_low_drained", 64'(o_valid), 64'd2);
    check_eq("dup_high_held",   o_data_bus,   {32'h1234_5678, 32'h0});
    step();
    check_eq("dup_high_still", o_data_bus, {32'h1234_5678, 32'h0});
    i_ready = 2'b10;
    step();
    check_eq("dup_high_drained", 64'(o_valid), 64'd0);
    i_ready = 2'b00;

    // Fill high branch, then stall a low-only word
    for (int k = 1; k <= 4; k++) begin
      i_valid = 2'b10; i_data_bus = {32'(k), 32'h0};
      step();
    end
    i_valid = 2'b01; i_data_bus = {32'h0, 32'h5};
    #1;
    check_eq("full_flag",  64'(o_full),  64'd2);
    check_eq("full_ready", 64'(o_ready), 64'd0);
    check_eq("full_head",  o_data_bus,   {32'd1, 32'h0});
    step();
    check_eq("stall_valid", 64'(o_valid), 64'd2);
    check_eq("stall_ready", 64'(o_ready), 64'd0);
    i_ready = 2'b10;
    step();
    i_ready = 2'b00;
    check_eq("after_pop_ready", 64'(o_ready), 64'd1);
    check_eq("after_pop_head",  o_data_bus,   {32'd2, 32'h0});
    check_eq("after_pop_lowq",  64'(o_valid), 64'd2);
    step();
    i_valid = 2'b00; i_data_bus = '0;
    check_eq("fifth_accepted", 64'(o_valid), 64'd3);
    check_eq("fifth_bus",      o_data_bus,   {32'd2, 32'd5});
    check_eq("fifth_full",     64'(o_full),  64'd0);
    i_ready = 2'b11;
    step();
    check_eq("drain_3", o_data_bus, {32'd3, 32'd0});
    step();
    check_eq("drain_4", o_data_bus, {32'd4, 32'd0});
    step();
    check_eq("drain_empty", 64'(o_empty), 64'd3);

    // Steady-state stream with concurrent push and pop
    for (int k = 0; k < 16; k++) begin
      i_valid = 2'b11; i_data_bus = {32'(k), 32'(k)};
      #1;
      check_eq("stream_ready", 64'(o_ready), 64'd1);
      step();
      check_eq("stream_bus",   o_data_bus,   {32'(k), 32'(k)});
      check_eq("stream_empty", 64'(o_empty), 64'd0);
      check_eq("stream_full",  64'(o_full),  64'd0);
    end
    i_valid = 2'b00; i_data_bus = '0;
    step();
    check_eq("stream_done", 64'(o_valid), 64'd0);

    // Reset with three words buffered in each branch
    i_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      i_valid = 2'b11; i_data_bus = {32'(100 + k), 32'(200 + k)};
      step();
    end
    i_valid = 2'b00; i_data_bus = '0;
    check_eq("pre_rst_bus", o_data_bus, {32'd100, 32'd200});
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ready", 64'(o_ready), 64'd0);
    step();
    check_eq("post_rst_valid", 64'(o_valid), 64'd0);
    check_eq("post_rst_bus",   o_data_bus,   64'd0);
    rst = 1'b0;
    i_ready = 2'b11;
    step();
    check_eq("no_stale_valid", 64'(o_valid), 64'd0);
    check_eq("no_stale_bus",   o_data_bus,   64'd0);
    check_eq("no_stale_ready", 64'(o_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
